// File: rtl/data_mem_bytes.sv
// Byte-addressable RV32 data memory: LB/LH/LW/LBU/LHU/SB/SH/SW with byte enables,
// one-cycle registered load response, and a post-reset clear of one word per cycle.
module data_mem_bytes #(
    parameter int DEPTH = 1024,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        REQ_VALID,
    output logic        REQ_READY,
    input  logic        WE,
    input  logic [2:0]  FUNCT3,
    input  logic [31:0] A,
    input  logic [31:0] WD,
    output logic        RSP_VALID,
    output logic [31:0] RD,
    output logic        ERR,
    output logic        BUSY
);

    // Handshake: a request is taken on a rising edge where REQ_VALID && REQ_READY;
    // RSP_VALID pulses for one cycle with no backpressure from the consumer.
    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   clr_cnt_q, clr_cnt_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic            err_q, err_d;
    logic [31:0]     rd_q, rd_d;
    logic [31:0]     mem_q [DEPTH];

    logic            accept;
    logic [AW-1:0]   word_idx;
    logic [1:0]      lane;
    logic            legal;
    logic            misaligned;
    logic            acc_err;
    logic [3:0]      st_be;
    logic [31:0]     st_data;
    logic            mem_we;
    logic [AW-1:0]   mem_idx;
    logic [3:0]      mem_be;
    logic [31:0]     mem_wdata;
    logic [31:0]     rd_word;
    logic [31:0]     ld_shift;
    logic [15:0]     ld_half;
    logic [31:0]     ld_data;

    // Upper address bits are deliberately ignored so addresses wrap modulo 4*DEPTH.
    logic unused_addr_bits;
    assign unused_addr_bits = ^A[31:AW+2];

    assign accept   = REQ_VALID && REQ_READY;
    assign word_idx = A[AW+1:2];
    assign lane     = A[1:0];

    always_comb begin
        legal      = 1'b0;
        misaligned = 1'b0;
        case (FUNCT3)
            3'b000: legal = 1'b1;
            3'b001: begin legal = 1'b1; misaligned = A[0];    end
            3'b010: begin legal = 1'b1; misaligned = |A[1:0]; end
            3'b100: legal = !WE;
            3'b101: begin legal = !WE;  misaligned = A[0];    end
            default: legal = 1'b0;
        endcase
        acc_err = !legal || misaligned;
    end

    always_comb begin
        st_be   = 4'hF;
        st_data = WD;
        case (FUNCT3[1:0])
            2'b00: begin
                st_be   = 4'b0001 << lane;
                st_data = {4{WD[7:0]}};
            end
            2'b01: begin
                st_be   = A[1] ? 4'b1100 : 4'b0011;
                st_data = {2{WD[15:0]}};
            end
            default: begin
                st_be   = 4'hF;
                st_data = WD;
            end
        endcase
    end

    // The clear sweep owns the write port; requests cannot be accepted meanwhile.
    always_comb begin
        mem_we    = 1'b0;
        mem_idx   = word_idx;
        mem_be    = st_be;
        mem_wdata = st_data;
        if (state_q == ST_CLEAR) begin
            mem_we    = 1'b1;
            mem_idx   = clr_cnt_q;
            mem_be    = 4'hF;
            mem_wdata = '0;
        end else if (accept && WE && !acc_err) begin
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST && mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (mem_be[i]) begin
                    mem_q[mem_idx][8*i +: 8] <= mem_wdata[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        rd_word  = mem_q[word_idx];
        ld_shift = rd_word >> {lane, 3'b000};
        ld_half  = A[1] ? rd_word[31:16] : rd_word[15:0];
        case (FUNCT3)
            3'b000:  ld_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_data = {24'h0, ld_shift[7:0]};
            3'b101:  ld_data = {16'h0, ld_half};
            default: ld_data = rd_word;
        endcase
    end

    always_comb begin
        rsp_valid_d = accept && (!WE || acc_err);
        err_d       = accept && acc_err;
        rd_d        = (accept && !WE && !acc_err) ? ld_data : '0;
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q     <= ST_CLEAR;
            clr_cnt_q   <= '0;
            rsp_valid_q <= 1'b0;
            err_q       <= 1'b0;
            rd_q        <= '0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            rsp_valid_q <= rsp_valid_d;
            err_q       <= err_d;
            rd_q        <= rd_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        if (state_q == ST_CLEAR) begin
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (&clr_cnt_q) begin
                state_d = ST_IDLE;
            end
        end
    end

    always_comb begin
        REQ_READY = (state_q == ST_IDLE);
        BUSY      = (state_q == ST_CLEAR);
    end

    assign RSP_VALID = rsp_valid_q;
    assign ERR       = err_q;
    assign RD        = rd_q;

endmodule

// File: tb/tb_data_mem_bytes.sv
// Directed bench for data_mem_bytes (DEPTH=16): clear timing, byte/half access,
// errors, wrap, back-to-back loads, reset mid-operation and requests during clear.
module tb_data_mem_bytes;

    localparam int DEPTH = 16;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        rsp_valid;
    logic [31:0] rd;
    logic        err;
    logic        busy;

    int n_assert;
    int n_fail;

    data_mem_bytes #(.DEPTH(DEPTH)) dut (
        .CLK       (clk),
        .RST       (rst_n),
        .REQ_VALID (req_valid),
        .REQ_READY (req_ready),
        .WE        (we),
        .FUNCT3    (funct3),
        .A         (addr),
        .WD        (wd),
        .RSP_VALID (rsp_valid),
        .RD        (rd),
        .ERR       (err),
        .BUSY      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Presents one request for exactly one edge; outputs are then sampled #1 later.
    task automatic do_req(input logic w, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] d);
        req_valid = 1'b1;
        we        = w;
        funct3    = f3;
        addr      = a;
        wd        = d;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic load_check(input string tag, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] exp);
        do_req(1'b0, f3, a, 32'h0);
        check({tag, ".rsp"}, {31'b0, rsp_valid}, 32'd1);
        check({tag, ".err"}, {31'b0, err}, 32'd0);
        check({tag, ".rd"}, rd, exp);
    endtask

    task automatic store(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d);
        do_req(1'b1, f3, a, d);
        check({tag, ".norsp"}, {31'b0, rsp_valid}, 32'd0);
    endtask

    task automatic err_check(input string tag, input logic w, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] d);
        do_req(w, f3, a, d);
        check({tag, ".rsp"}, {31'b0, rsp_valid}, 32'd1);
        check({tag, ".err"}, {31'b0, err}, 32'd1);
        check({tag, ".rd"}, rd, 32'h0);
    endtask

    // Exactly DEPTH edges after release: busy before, ready on the last one.
    task automatic clear_check(input string tag);
        for (int c = 1; c <= DEPTH; c++) begin
            @(posedge clk);
            #1;
            check({tag, ".no_rsp"}, {31'b0, rsp_valid}, 32'd0);
            if (c < DEPTH) begin
                check({tag, ".busy"}, {31'b0, busy}, 32'd1);
                check({tag, ".not_ready"}, {31'b0, req_ready}, 32'd0);
            end else begin
                check({tag, ".idle"}, {31'b0, busy}, 32'd0);
                check({tag, ".ready"}, {31'b0, req_ready}, 32'd1);
            end
        end
    endtask

    initial begin
        n_assert  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        we        = 1'b0;
        funct3    = 3'b010;
        addr      = 32'h0;
        wd        = 32'h0;

        // Reset held for 3 cycles, then the clear sweep.
        repeat (3) begin
            @(posedge clk);
            #1;
            check("rst.ready", {31'b0, req_ready}, 32'd0);
            check("rst.rsp", {31'b0, rsp_valid}, 32'd0);
            check("rst.rd", rd, 32'h0);
            check("rst.err", {31'b0, err}, 32'd0);
            check("rst.busy", {31'b0, busy}, 32'd1);
        end
        rst_n = 1'b1;
        clear_check("clear1");
        for (int i = 0; i < DEPTH; i++) begin
            load_check("clr_lw", 3'b010, 32'(i * 4), 32'h0);
        end

        // Byte and halfword stores/loads.
        store("sw8", 3'b010, 32'h8, 32'h11223344);
        store("sba", 3'b000, 32'hA, 32'h000000AA);
        store("sh8", 3'b001, 32'h8, 32'h0000BEEF);
        load_check("lw8", 3'b010, 32'h8, 32'h11AABEEF);
        load_check("lba", 3'b000, 32'hA, 32'hFFFFFFAA);
        load_check("lbua", 3'b100, 32'hA, 32'h000000AA);
        load_check("lh8", 3'b001, 32'h8, 32'hFFFFBEEF);
        load_check("lhu8", 3'b101, 32'h8, 32'h0000BEEF);
        load_check("lha", 3'b001, 32'hA, 32'h000011AA);
        load_check("lbb", 3'b000, 32'hB, 32'h00000011);
        load_check("lb9", 3'b000, 32'h9, 32'hFFFFFFBE);
        load_check("lbu9", 3'b100, 32'h9, 32'h000000BE);

        // Misaligned and illegal accesses leave the array untouched.
        store("sw0", 3'b010, 32'h0, 32'h12345678);
        err_check("sw_mis1", 1'b1, 3'b010, 32'h1, 32'h00000005);
        load_check("lw0_kept", 3'b010, 32'h0, 32'h12345678);
        err_check("lh_mis3", 1'b0, 3'b001, 32'h3, 32'h0);
        err_check("ld_f011", 1'b0, 3'b011, 32'h0, 32'h0);
        err_check("st_f100", 1'b1, 3'b100, 32'h0, 32'hFFFFFFFF);
        err_check("sh_mis1", 1'b1, 3'b001, 32'h1, 32'hFFFFFFFF);
        err_check("lw_mis2", 1'b0, 3'b010, 32'h2, 32'h0);
        err_check("ld_f111", 1'b0, 3'b111, 32'h0, 32'h0);
        err_check("st_f101", 1'b1, 3'b101, 32'h0, 32'hFFFFFFFF);
        load_check("lw0_kept2", 3'b010, 32'h0, 32'h12345678);
        load_check("lhu2_ok", 3'b101, 32'h2, 32'h00001234);

        // Address wrap and back-to-back loads.
        store("sw40", 3'b010, 32'h40, 32'hCAFEF00D);
        store("sw4", 3'b010, 32'h4, 32'h600DF00D);
        load_check("wrap_lw0", 3'b010, 32'h0, 32'hCAFEF00D);
        load_check("b2b_lw0", 3'b010, 32'h0, 32'hCAFEF00D);
        load_check("b2b_lw4", 3'b010, 32'h4, 32'h600DF00D);
        @(posedge clk);
        #1;
        check("idle.rsp", {31'b0, rsp_valid}, 32'd0);
        check("idle.rd", rd, 32'h0);

        // Store then load of the same word on consecutive edges.
        store("sw_raw", 3'b010, 32'hC, 32'hA5A55A5A);
        load_check("lw_raw", 3'b010, 32'hC, 32'hA5A55A5A);

        // Reset mid-operation discards the response and restarts the clear.
        load_check("pre_rst", 3'b010, 32'h0, 32'hCAFEF00D);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrst.rsp", {31'b0, rsp_valid}, 32'd0);
        check("midrst.rd", rd, 32'h0);
        check("midrst.busy", {31'b0, busy}, 32'd1);
        check("midrst.ready", {31'b0, req_ready}, 32'd0);
        do_req(1'b0, 3'b010, 32'h4, 32'h0);
        check("rstld.rsp", {31'b0, rsp_valid}, 32'd0);
        check("rstld.rd", rd, 32'h0);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("part_clear.busy", {31'b0, busy}, 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // A store held during the whole clear must be ignored.
        req_valid = 1'b1;
        we        = 1'b1;
        funct3    = 3'b010;
        addr      = 32'h0;
        wd        = 32'hFFFFFFFF;
        clear_check("clear2");
        req_valid = 1'b0;
        load_check("post_clr_lw0", 3'b010, 32'h0, 32'h0);
        load_check("post_clr_lw4", 3'b010, 32'h4, 32'h0);
        load_check("post_clr_lw8", 3'b010, 32'h8, 32'h0);
        load_check("post_clr_lwc", 3'b010, 32'hC, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/data_mem_bytes.md
# data_mem_bytes

Parametrised, byte-addressable data memory for the RV32 core's load/store path, replacing the flat word array. It supports all RV32I load/store widths (LB/LH/LW/LBU/LHU/SB/SH/SW) with byte enables and sign/zero extension. Accesses use a single-port valid/ready handshake with registered read data. After reset, a clear state machine zeroes the array one word per cycle.

## Interface
Parameters:
- DEPTH, 1024, number of 32-bit words; must be a power of two, at least 2.
- AW, log2(DEPTH), word-index width; derived, not overridden.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RST  in  1  reset, synchronous and active-low.
- REQ_VALID  in  1  request present.
- REQ_READY  out  1  block can accept a request this cycle.
- WE  in  1  1 = store, 0 = load.
- FUNCT3  in  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- A  in  32  byte address.
- WD  in  32  store data; the low byte or halfword is used for B/H.
- RSP_VALID  out  1  one-cycle pulse; load data or error is valid.
- RD  out  32  extended load data.
- ERR  out  1  qualifies RSP_VALID; set for a misaligned or illegal access.
- BUSY  out  1  high while the clear state machine runs.

## Operation
- Accept condition: REQ_VALID && REQ_READY, sampled at the rising edge.
- Word index is A[AW+1:2]. Upper address bits are ignored, so the address wraps modulo 4·DEPTH bytes.
- Byte lane is A[1:0].
- Legal FUNCT3 values:
  - loads: 000, 001, 010, 100, 101.
  - stores: 000, 001, 010.
  - Anything else is illegal.
- Misaligned access: H/HU with A[0]=1, or W with A[1:0]≠00.
- Store (legal, aligned):
  - Writes only the addressed lanes. SB writes WD[7:0] to lane A[1:0]. SH writes WD[15:0] to lanes {A[1],0}+1..{A[1],0}. SW writes all 4 lanes.
  - Other bytes are untouched.
  - No response is produced.
- Load (legal, aligned):
  - Selects the addressed byte or halfword, shifts it to bit 0, then sign-extends (B, H) or zero-extends (BU, HU). W passes through.
  - Returns the result with RSP_VALID=1, ERR=0.
- Error (illegal or misaligned, load or store):
  - The array is not modified.
  - Response is RSP_VALID=1, ERR=1, RD=0.
- State machine:
  - CLEAR: clear counter k runs 0..DEPTH-1, writing word k to 0 each cycle. REQ_READY=0, BUSY=1. Go to IDLE after k=DEPTH-1 is written.
  - IDLE: REQ_READY=1, BUSY=0. One request accepted per cycle.
- Any cycle with RST=0:
  - State becomes CLEAR and k becomes 0.
  - RSP_VALID, ERR and RD become 0.
  - Any pending load response is discarded.
  - The array is not written in that cycle.

## Timing
- Reset values while RST=0: REQ_READY=0, RSP_VALID=0, RD=0, ERR=0, BUSY=1.
- Clear latency: the first edge with RST=1 writes word 0. REQ_READY rises exactly DEPTH cycles after RST goes high.
- Load latency is 1 cycle. For a load accepted at edge n, RSP_VALID, RD and ERR are valid in the cycle after edge n and drop at edge n+1 unless another response follows.
- Store latency: written at the accept edge; visible to a load accepted at the next edge.
- Back-to-back loads produce responses every cycle, in order.
- A store followed by a load to the same address in consecutive cycles returns the new data; no bypass is needed.
- RSP_VALID is 0 in cycles with no accepted load and no error. There is no response backpressure; the consumer must take RSP_VALID when it pulses.
- REQ_VALID while REQ_READY=0 is ignored; no request is queued.
- RST low mid-clear restarts the clear at k=0.

## Test plan
- Reset/clear, DEPTH=16:
  - Hold RST=0 for 3 cycles, release.
  - Expect BUSY=1 and REQ_READY=0 for 16 cycles, then REQ_READY=1.
  - LW of 0x0..0x3C all return 0x00000000, ERR=0.
- Byte/half stores and loads:
  - SW 0x11223344 @0x8, then SB 0xAA @0xA, then SH 0xBEEF @0x8.
  - LW @0x8 returns 0x11AABEEF.
  - LB @0xA returns 0xFFFFFFAA. LBU @0xA returns 0x000000AA.
  - LH @0x8 returns 0xFFFFBEEF. LHU @0x8 returns 0x0000BEEF.
- Misaligned and illegal:
  - SW 0x5 @0x1 gives RSP_VALID=1, ERR=1, RD=0.
  - LW @0x0 then returns its prior value.
  - LH @0x3 gives ERR=1.
  - FUNCT3=011 load gives ERR=1.
  - FUNCT3=100 store gives ERR=1 with no write.
- Back-to-back and wrap:
  - With DEPTH=16, SW 0xCAFEF00D @0x40.
  - LW @0x0 returns 0xCAFEF00D (wrap).
  - LW @0x0 and LW @0x4 issued on consecutive cycles give RSP_VALID high for 2 consecutive cycles with in-order data.
- Reset mid-operation:
  - Issue LW, then assert RST=0 on the next edge.
  - No RSP_VALID appears; RD=0.
  - After release, the full clear repeats; the previously written data reads as 0.
- Request during clear:
  - Hold REQ_VALID=1 with SW 0xFFFFFFFF @0x0 during CLEAR.
  - No write occurs; LW @0x0 after CLEAR returns 0.
